ps2_kbd_dev_io: RTL and testbench

- Memory-mapped PS/2 keyboard receiver peripheral. It sits downstream of the MIO bus, alongside the LED, counter and seven-segment peripherals, and is clocked by clk_IO.
- It samples the external PS/2 clock and data lines, deframes 11-bit scan-code frames and buffers good bytes in a small FIFO.
- It presents a 32-bit status/data word and a pop strobe to the bus. This gives the CPU polled or interrupt-driven keyboard input.

---
 rtl/ps2_kbd_dev_io_if.sv | 22 ++
 rtl/ps2_kbd_dev_io.sv | 199 +++++++++++++++++++
 tb/tb_ps2_kbd_dev_io.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_dev_io_if.sv
// Bus-side signal bundle of the PS/2 keyboard peripheral: pop/clear strobes in,
// status/data word and interrupt out.
interface ps2_kbd_dev_io_if;
   logic        kbd_rd;
   logic        kbd_clr;
   logic [31:0] kbd_out;
   logic        kbd_irq;

   modport master (
      output kbd_rd,
      output kbd_clr,
      input  kbd_out,
      input  kbd_irq
   );

   modport slave (
      input  kbd_rd,
      input  kbd_clr,
      output kbd_out,
      output kbd_irq
   );
endinterface

// File: rtl/ps2_kbd_dev_io.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames,
// buffers good scan-code bytes in a FIFO and exposes status/data to the MIO bus.
module ps2_kbd_dev_io #(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 12500
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   ps2_kbd_dev_io_if.slave   bus
);

   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // Frame is good when start=0, data+parity has an odd number of ones, stop=1.
   function automatic logic frame_good(input logic [10:0] fr);
      return (fr[0] == 1'b0) && (^fr[9:1] == 1'b1) && (fr[10] == 1'b1);
   endfunction

   logic [1:0]    clk_sync_r;
   logic [1:0]    dat_sync_r;
   logic          clk_prev_r;
   logic          fall_s;
   logic          data_s;

   state_t        state_r;
   state_t        state_n;
   logic [3:0]    bit_cnt_r;
   logic [3:0]    bit_cnt_n;
   logic [10:0]   frame_r;
   logic [10:0]   frame_n;
   logic [15:0]   to_cnt_r;
   logic          push_req_s;
   logic          frame_bad_s;

   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [3:0]    count_r;
   logic          ovf_r;
   logic          perr_r;
   logic          pop_ok_s;
   logic          push_ok_s;
   logic          ovf_set_s;
   logic          full_s;
   logic          valid_s;
   logic [7:0]    head_s;

   // Two-stage synchronisers plus previous-clock register; lines idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_r <= 2'b11;
         dat_sync_r <= 2'b11;
         clk_prev_r <= 1'b1;
      end else begin
         clk_sync_r <= {clk_sync_r[0], ps2_clk};
         dat_sync_r <= {dat_sync_r[0], ps2_data};
         clk_prev_r <= clk_sync_r[1];
      end
   end

   assign fall_s = clk_prev_r & ~clk_sync_r[1];
   assign data_s = dat_sync_r[1];

   // Deframer state, bit index and frame shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= 4'd0;
         frame_r   <= 11'd0;
      end else begin
         state_r   <= state_n;
         bit_cnt_r <= bit_cnt_n;
         frame_r   <= frame_n;
      end
   end

   // Deframer next-state logic, including the inter-edge timeout abort.
   always_comb begin
      state_n     = state_r;
      bit_cnt_n   = bit_cnt_r;
      frame_n     = frame_r;
      push_req_s  = 1'b0;
      frame_bad_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s && !data_s) begin
               state_n   = ST_RECV;
               bit_cnt_n = 4'd1;
               frame_n   = 11'd0;
            end else begin
               state_n   = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (fall_s) begin
               frame_n[bit_cnt_r] = data_s;
               bit_cnt_n          = bit_cnt_r + 4'd1;
               if (bit_cnt_r == 4'd10) begin
                  state_n = ST_CHECK;
               end else begin
                  state_n = ST_RECV;
               end
            end else if (to_cnt_r >= TO_LIM) begin
               state_n   = ST_IDLE;
               bit_cnt_n = 4'd0;
            end else begin
               state_n   = ST_RECV;
            end
         end
         ST_CHECK: begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            if (frame_good(frame_r)) begin
               push_req_s = 1'b1;
            end else begin
               frame_bad_s = 1'b1;
            end
         end
         default: begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
         end
      endcase
   end

   // Inter-edge timeout counter: runs only while a frame is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_r <= 16'd0;
      end else if (fall_s || (state_r != ST_RECV)) begin
         to_cnt_r <= 16'd0;
      end else begin
         to_cnt_r <= to_cnt_r + 16'd1;
      end
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
   always_comb begin
      full_s    = (count_r == DEPTH_C);
      pop_ok_s  = bus.kbd_rd && (count_r != 4'd0);
      push_ok_s = push_req_s && (!full_s || pop_ok_s);
      ovf_set_s = push_req_s && full_s && !pop_ok_s;
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= 4'd0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= frame_r[8:1];
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + {3'b000, push_ok_s} - {3'b000, pop_ok_s};
      end
   end

   // Sticky error flags; a same-cycle set beats the clear strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r  <= 1'b0;
         perr_r <= 1'b0;
      end else begin
         ovf_r  <= ovf_set_s   | (ovf_r  & ~bus.kbd_clr);
         perr_r <= frame_bad_s | (perr_r & ~bus.kbd_clr);
      end
   end

   // Bus-facing status/data word, decoded from registers only.
   always_comb begin
      valid_s = (count_r != 4'd0);
      if (valid_s) begin
         head_s = mem_r[rd_ptr_r];
      end else begin
         head_s = 8'h00;
      end
      bus.kbd_out = {valid_s, ovf_r, perr_r, 1'b0, count_r, 16'h0000, head_s};
      bus.kbd_irq = valid_s | ovf_r;
   end

endmodule

// File: tb/tb_ps2_kbd_dev_io.sv
// Directed bench for ps2_kbd_dev_io: drives PS/2 frames, keeps a byte/flag
// scoreboard and checks the bus word and interrupt with immediate assertions.
`timescale 1ns/1ps
module tb_ps2_kbd_dev_io;

   localparam int DEPTH = 8;
   localparam int TO    = 12500;

   logic clk;
   logic rst_n;
   logic ps2_clk;
   logic ps2_data;

   ps2_kbd_dev_io_if bus_if ();

   ps2_kbd_dev_io #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus_if.slave)
   );

   initial clk = 1'b0;
   always #40 clk = ~clk;

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] q [$];
   logic       m_ovf  = 1'b0;
   logic       m_perr = 1'b0;

   initial begin
      #20ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] exp_word();
      logic [7:0] h;
      h = (q.size() != 0) ? q[0] : 8'h00;
      return {(q.size() != 0), m_ovf, m_perr, 1'b0, 4'(q.size()), 16'h0000, h};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag);
      check({tag, "_out"}, bus_if.kbd_out, exp_word());
      check({tag, "_irq"}, {31'd0, bus_if.kbd_irq},
            {31'd0, (q.size() != 0) | m_ovf});
   endtask

   // Sends the first n bits of fr LSB first; optional pop timed to the CHECK cycle.
   task automatic send_bits(input logic [10:0] fr, input int n, input int half,
                            input bit rd_at_check);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ps2_data = fr[i];
         repeat (half) @(negedge clk);
         ps2_clk = 1'b0;
         if (rd_at_check && i == 10) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("rd_at_check_head", {24'd0, bus_if.kbd_out[7:0]}, {24'd0, q[0]});
            bus_if.kbd_rd = 1'b1;
            @(negedge clk);
            bus_if.kbd_rd = 1'b0;
            void'(q.pop_front());
            repeat (half - 2) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
   endtask

   // Full frame with odd parity, or the parity bit inverted when bad_par is set.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half,
                             input bit rd_at_check);
      logic       par;
      logic [10:0] fr;
      par = bad_par ? ^b : ~^b;
      fr  = {1'b1, par, b, 1'b0};
      send_bits(fr, 11, half, rd_at_check);
      if (bad_par) begin
         m_perr = 1'b1;
      end else if (q.size() >= DEPTH) begin
         m_ovf = 1'b1;
      end else begin
         q.push_back(b);
      end
   endtask

   task automatic pop(input string tag);
      @(negedge clk);
      check_bus(tag);
      bus_if.kbd_rd = 1'b1;
      @(negedge clk);
      bus_if.kbd_rd = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic clr();
      @(negedge clk);
      bus_if.kbd_clr = 1'b1;
      @(negedge clk);
      bus_if.kbd_clr = 1'b0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      ps2_clk        = 1'b1;
      ps2_data       = 1'b1;
      bus_if.kbd_rd  = 1'b0;
      bus_if.kbd_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", bus_if.kbd_out, 32'h00000000);
      check("reset_irq", {31'd0, bus_if.kbd_irq}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_bus("post_reset");

      // One good frame at a 1000-clk bit period, then pop it.
      send_frame(8'h1C, 1'b0, 500, 1'b0);
      check("good_1c", bus_if.kbd_out, 32'h8100001C);
      check("good_1c_irq", {31'd0, bus_if.kbd_irq}, 32'd1);
      pop("pop_1c");
      check("after_pop_1c", bus_if.kbd_out, 32'h00000000);
      check("after_pop_1c_irq", {31'd0, bus_if.kbd_irq}, 32'd0);

      // Parity error: byte discarded, perr sticky until cleared.
      send_frame(8'h1C, 1'b1, 50, 1'b0);
      check("perr", bus_if.kbd_out, 32'h20000000);
      check("perr_irq", {31'd0, bus_if.kbd_irq}, 32'd0);
      clr();
      check("perr_clr", bus_if.kbd_out, 32'h00000000);

      // Overflow: nine frames into an eight-deep FIFO.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 50, 1'b0);
      check("ovf_full", bus_if.kbd_out, 32'hC8000001);
      for (int i = 0; i < 8; i++) pop("drain_ovf");
      @(negedge clk);
      check("ovf_drained", bus_if.kbd_out, 32'h40000000);
      check_bus("ovf_drained_model");
      clr();
      check_bus("ovf_clr");

      // Full FIFO: frame completes in the same cycle as a pop.
      for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 50, 1'b0);
      check("fill8", bus_if.kbd_out, 32'h08000011 | 32'h80000000);
      send_frame(8'h5A, 1'b0, 50, 1'b1);
      check("full_pop_push", bus_if.kbd_out, 32'h88000012);
      for (int i = 0; i < 8; i++) pop("drain_full");
      @(negedge clk);
      check_bus("full_drained");

      // Partial frame abandoned by timeout, then a clean frame.
      send_bits(11'b000_0000_1010, 5, 50, 1'b0);
      repeat (TO + 10) @(negedge clk);
      check("timeout_quiet", bus_if.kbd_out, 32'h00000000);
      send_frame(8'hF0, 1'b0, 50, 1'b0);
      check("after_timeout_f0", bus_if.kbd_out, 32'h810000F0);
      pop("pop_f0");

      // Reset in the middle of a frame discards it and the buffered byte.
      send_frame(8'h33, 1'b0, 50, 1'b0);
      check_bus("pre_reset_33");
      send_bits(11'b110_0101_0100, 7, 50, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_reset", bus_if.kbd_out, 32'h00000000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(8'h2A, 1'b0, 50, 1'b0);
      check("after_reset_2a", bus_if.kbd_out, 32'h8100002A);
      pop("pop_2a");
      check("empty_2a", bus_if.kbd_out, 32'h00000000);
      pop("rd_empty");
      check("rd_empty_after", bus_if.kbd_out, 32'h00000000);
      check("rd_empty_irq", {31'd0, bus_if.kbd_irq}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
